// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter:
// FSM state encodings and requester IDs.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    ID_IO  = 1'b0,
    ID_CPU = 1'b1
  } req_id_e;

endpackage

// File: rtl/dram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between IO and CPU,
// with an IO-exclusive mode for the loader/dumper phase.
import dram_port_arbiter_pkg::*;

module rr_arb2 (
  input  logic    io_req,
  input  logic    cpu_req,
  input  logic    io_only,
  input  req_id_e last_grant,
  output logic    gnt_io,
  output logic    gnt_cpu,
  output logic    any
);

  logic cpu_ok;

  assign cpu_ok  = cpu_req & ~io_only;
  assign gnt_io  = io_req &
                   (~cpu_ok | (last_grant == ID_CPU));
  assign gnt_cpu = cpu_ok &
                   (~io_req | (last_grant == ID_IO));
  assign any     = gnt_io | gnt_cpu;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between IO and CPU, one access
// outstanding at a time, all outputs registered.
import dram_port_arbiter_pkg::*;

module dram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_only,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e     state;
  req_id_e    last_grant;
  req_id_e    owner;
  logic [LAT_W-1:0] lat_cnt;

  logic gnt_io;
  logic gnt_cpu;
  logic any;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .io_req     (io_req),
    .cpu_req    (cpu_req),
    .io_only    (io_only),
    .last_grant (last_grant),
    .gnt_io     (gnt_io),
    .gnt_cpu    (gnt_cpu),
    .any        (any)
  );

  assign sel_we    = gnt_io ? io_we    : cpu_we;
  assign sel_addr  = gnt_io ? io_addr  : cpu_addr;
  assign sel_wdata = gnt_io ? io_wdata : cpu_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= ID_CPU;
      owner      <= ID_IO;
      lat_cnt    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_write  <= 1'b0;
      ram_read   <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_gnt    <= 1'b0;
      io_rvalid  <= 1'b0;
      cpu_rvalid <= 1'b0;
      rdata      <= '0;
    end else begin
      io_gnt     <= 1'b0;
      cpu_gnt    <= 1'b0;
      ram_write  <= 1'b0;
      ram_read   <= 1'b0;
      io_rvalid  <= 1'b0;
      cpu_rvalid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            owner      <= gnt_io ? ID_IO : ID_CPU;
            last_grant <= gnt_io ? ID_IO : ID_CPU;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            ram_write  <= sel_we;
            ram_read   <= ~sel_we;
            io_gnt     <= gnt_io;
            cpu_gnt    <= gnt_cpu;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ram_read is still high here for a read access
          if (ram_read) begin
            lat_cnt <= LAT_W'(RD_LAT - 1);
            state   <= ST_RDWAIT;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_RDWAIT: begin
          if (lat_cnt == '0) begin
            rdata      <= ram_rdata;
            io_rvalid  <= (owner == ID_IO);
            cpu_rvalid <= (owner == ID_CPU);
            state      <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: RD_LAT=1
// instance plus an RD_LAT=3 instance.
module tb_dram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // RD_LAT = 1 instance
  logic        io_only, io_req, io_we;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_gnt, io_rvalid;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_write, ram_read;
  logic [7:0]  ram_rdata;
  logic [7:0]  rdata;
  logic [7:0]  ram0_val;

  dram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .io_only(io_only),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_gnt(io_gnt),
    .io_rvalid(io_rvalid), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_write(ram_write),
    .ram_read(ram_read), .ram_rdata(ram_rdata),
    .rdata(rdata)
  );

  always @(posedge clk)
    if (ram_read) ram_rdata <= ram0_val;

  // RD_LAT = 3 instance
  logic        io_only3, io_req3, io_we3;
  logic [15:0] io_addr3;
  logic [7:0]  io_wdata3;
  logic        io_gnt3, io_rvalid3;
  logic        cpu_req3, cpu_we3;
  logic [15:0] cpu_addr3;
  logic [7:0]  cpu_wdata3;
  logic        cpu_gnt3, cpu_rvalid3;
  logic [15:0] ram_addr3;
  logic [7:0]  ram_wdata3;
  logic        ram_write3, ram_read3;
  logic [7:0]  ram_rdata3;
  logic [7:0]  rdata3;
  logic [7:0]  ram3_val;
  logic [7:0]  p3_0, p3_1;

  dram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .io_only(io_only3),
    .io_req(io_req3), .io_we(io_we3), .io_addr(io_addr3),
    .io_wdata(io_wdata3), .io_gnt(io_gnt3),
    .io_rvalid(io_rvalid3), .cpu_req(cpu_req3),
    .cpu_we(cpu_we3), .cpu_addr(cpu_addr3),
    .cpu_wdata(cpu_wdata3), .cpu_gnt(cpu_gnt3),
    .cpu_rvalid(cpu_rvalid3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_write(ram_write3),
    .ram_read(ram_read3), .ram_rdata(ram_rdata3),
    .rdata(rdata3)
  );

  always @(posedge clk) begin
    if (ram_read3) p3_0 <= ram3_val;
    p3_1       <= p3_0;
    ram_rdata3 <= p3_1;
  end

  bit nxt_io;

  initial begin
    reset = 1'b1;
    io_only = 0; io_req = 0; io_we = 0;
    io_addr = 0; io_wdata = 0;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0;
    ram0_val = 0;
    io_only3 = 0; io_req3 = 0; io_we3 = 0;
    io_addr3 = 0; io_wdata3 = 0;
    cpu_req3 = 0; cpu_we3 = 0;
    cpu_addr3 = 0; cpu_wdata3 = 0;
    ram3_val = 0;

    // 1: reset state, then simultaneous requests
    repeat (3) step();
    chk("rst_io_gnt", io_gnt, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_rvalid", {io_rvalid, cpu_rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    step();
    io_req = 1; io_we = 1;
    io_addr = 16'h0010; io_wdata = 8'h11;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0020; cpu_wdata = 8'h22;
    step();
    chk("t1_io_gnt", io_gnt, 1);
    chk("t1_cpu_gnt0", cpu_gnt, 0);
    chk("t1_wr", ram_write, 1);
    chk("t1_addr", ram_addr, 16'h0010);
    chk("t1_wdata", ram_wdata, 8'h11);
    io_req = 0;
    step();
    chk("t1_issue", {io_gnt, cpu_gnt, ram_write}, 0);
    chk("t1_hold_addr", ram_addr, 16'h0010);
    step();
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_addr2", ram_addr, 16'h0020);
    chk("t1_wdata2", ram_wdata, 8'h22);
    cpu_req = 0;
    step();

    // 2: io_only with CPU requesting
    io_only = 1;
    cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 4; i++) begin
      io_req = 1; io_we = 1;
      io_addr = 16'(i); io_wdata = 8'(8'h40 + i);
      step();
      chk("t2_io_gnt", io_gnt, 1);
      chk("t2_wr", ram_write, 1);
      chk("t2_addr", ram_addr, 32'(i));
      chk("t2_wdata", ram_wdata, 32'(8'h40 + i));
      chk("t2_cpu_gnt", cpu_gnt, 0);
      io_req = 0;
      step();
      chk("t2_cpu_gnt_b", cpu_gnt, 0);
    end
    cpu_req = 0;
    io_only = 0;
    step();
    chk("t2_cpu_idle", cpu_gnt, 0);

    // 3: both held; last grant was IO so CPU first
    io_req = 1; io_we = 1; io_addr = 16'h0100;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200;
    nxt_io = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_io_gnt", io_gnt, 32'(nxt_io));
      chk("t3_cpu_gnt", cpu_gnt, 32'(!nxt_io));
      chk("t3_addr", ram_addr,
          nxt_io ? 32'h0100 : 32'h0200);
      step();
      chk("t3_gap", {io_gnt, cpu_gnt}, 0);
      nxt_io = !nxt_io;
    end
    io_req = 0; cpu_req = 0;
    step();

    // 4: CPU read with RD_LAT=1
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    ram0_val = 8'hA5;
    step();
    chk("t4_gnt", cpu_gnt, 1);
    chk("t4_rd", ram_read, 1);
    chk("t4_addr", ram_addr, 16'h1234);
    cpu_req = 0;
    step();
    chk("t4_n2_rvalid", cpu_rvalid, 0);
    chk("t4_n2_rd", ram_read, 0);
    step();
    chk("t4_rvalid", cpu_rvalid, 1);
    chk("t4_rdata", rdata, 8'hA5);
    chk("t4_io_rvalid", io_rvalid, 0);
    step();
    chk("t4_pulse", cpu_rvalid, 0);
    chk("t4_rdata_hold", rdata, 8'hA5);

    // 5: RD_LAT=3, IO read then pending CPU write
    io_req3 = 1; io_we3 = 0; io_addr3 = 16'h0042;
    cpu_req3 = 1; cpu_we3 = 1;
    cpu_addr3 = 16'h0099; cpu_wdata3 = 8'h5E;
    ram3_val = 8'h3C;
    step();
    chk("t5_io_gnt", io_gnt3, 1);
    chk("t5_rd", ram_read3, 1);
    chk("t5_addr", ram_addr3, 16'h0042);
    io_req3 = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t5_wait_rvalid", io_rvalid3, 0);
      chk("t5_wait_cpu", cpu_gnt3, 0);
    end
    step();
    chk("t5_rvalid", io_rvalid3, 1);
    chk("t5_rdata", rdata3, 8'h3C);
    chk("t5_cpu_rvalid", cpu_rvalid3, 0);
    chk("t5_cpu_wait", cpu_gnt3, 0);
    step();
    chk("t5_cpu_gnt", cpu_gnt3, 1);
    chk("t5_cpu_wr", ram_write3, 1);
    chk("t5_cpu_addr", ram_addr3, 16'h0099);
    chk("t5_pulse", io_rvalid3, 0);
    cpu_req3 = 0;
    step();

    // 6: reset during RDWAIT aborts the read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    ram0_val = 8'h77;
    step();
    chk("t6_gnt", cpu_gnt, 1);
    cpu_req = 0;
    step();
    chk("t6_pre_rvalid", cpu_rvalid, 0);
    reset = 1'b1;
    #1;
    chk("t6_addr", ram_addr, 0);
    chk("t6_rdata", rdata, 0);
    chk("t6_strobes", {ram_read, ram_write}, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t6_rst_rvalid", {io_rvalid, cpu_rvalid}, 0);
    end
    reset = 1'b0;
    step();
    chk("t6_post_rvalid", {io_rvalid, cpu_rvalid}, 0);
    io_req = 1; io_we = 0; io_addr = 16'h0007;
    ram0_val = 8'h5A;
    step();
    chk("t6_io_gnt", io_gnt, 1);
    chk("t6_io_rd", ram_read, 1);
    chk("t6_io_addr", ram_addr, 16'h0007);
    io_req = 0;
    step();
    chk("t6_io_n2", io_rvalid, 0);
    step();
    chk("t6_io_rvalid", io_rvalid, 1);
    chk("t6_io_rdata", rdata, 8'h5A);
    chk("t6_cpu_rvalid", cpu_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
